lvds_tx_pll_ctrl: RTL
=====================

Name: lvds_tx_pll_ctrl

Overview:
- Power-up and recovery sequencer for the LVDS 7:1 TX PLL.
- Drives the PLL reset and qualifies its lock output.
- Holds the downstream serializer/gearbox in reset until the PLL lock has been stable for a programmed time.
- Re-runs the sequence on lock loss. After a bounded number of failed lock attempts it declares a fault.
- Runs on the free-running PLL input clock, upstream of the TX serializer reset tree.

Parameters:
- RST_CYCLES, 16: width of the PLL reset pulse, in clkin cycles (>=1).
- LOCK_TIMEOUT, 70200: cycles to wait for lock after reset release (~1 ms at 70.2 MHz).
- LOCK_STABLE, 256: consecutive lock-high cycles required before lock is declared (>=1).
- MAX_RETRY, 7: failed lock attempts allowed before FAULT.
- CNT_W, 17: width of the shared cycle counter. Must hold max(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE).

Ports:
- clkin  in  1  free-running PLL reference clock; the only clock.
- reset  in  1  synchronous, active-high block reset.
- en  in  1  level enable; 1 = bring up and keep the PLL running.
- pll_lock  in  1  raw PLL lock, asynchronous to clkin.
- pll_reset  out  1  to PLL RESET, active-high.
- ser_reset  out  1  downstream serializer reset, active-high.
- ready  out  1  1 = PLL locked and stable, serializer released.
- fault  out  1  1 = retries exhausted.
- lock_lost  out  1  single-cycle pulse on lock loss while in RUN.
- retry_cnt  out  3  failed attempts in the current bring-up.
- state  out  3  IDLE=0, PLL_RST=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5.

Behaviour:
- One clock (clkin). reset is synchronous and active-high.
- On reset:
  - state=IDLE, pll_reset=1, ser_reset=1, ready=0, fault=0, lock_lost=0, retry_cnt=0, counter=0.
  - Both lock synchronizer flops are cleared to 0.
- Lock synchronizer: pll_lock passes through a 2-FF synchronizer, giving lock_s. That is 2 cycles of latency; only lock_s is used internally.
- All outputs are registered and decoded from the next state, so they change on the same edge as state.
- Priority order: reset > en=0 > state transitions.
- en=0 in any state: go to IDLE on the next edge. That sets pll_reset=1, ser_reset=1, ready=0, fault=0, retry_cnt=0.
- IDLE:
  - pll_reset=1, ser_reset=1.
  - en=1 -> PLL_RST, counter=0.
- PLL_RST:
  - pll_reset=1, ser_reset=1. Counter increments each cycle.
  - When counter==RST_CYCLES-1 -> WAIT_LOCK, counter=0. The pulse is exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_reset=0, ser_reset=1. Counter increments each cycle.
  - lock_s=1 -> STABLE, counter=0.
  - Else if counter==LOCK_TIMEOUT-1, check retries:
    - retry_cnt==MAX_RETRY -> FAULT.
    - Otherwise retry_cnt+1 -> PLL_RST, counter=0.
  - If lock_s=1 and timeout occur on the same cycle, lock wins.
- STABLE:
  - pll_reset=0, ser_reset=1.
  - Counter counts consecutive lock_s=1 cycles.
  - lock_s=0 -> WAIT_LOCK, counter=0. retry_cnt is unchanged and a fresh timeout window starts.
  - When counter==LOCK_STABLE-1 with lock_s=1 -> RUN, retry_cnt=0.
- RUN:
  - pll_reset=0, ser_reset=0, ready=1.
  - lock_s=0 -> PLL_RST on the next edge: lock_lost=1 for that one cycle, ready=0, ser_reset=1, counter=0.
- FAULT:
  - pll_reset=1, ser_reset=1, ready=0, fault=1.
  - Held until en=0 (-> IDLE, fault cleared) or reset.
- retry_cnt saturates at MAX_RETRY; it never wraps.
- Counter compares are equality, in CNT_W bits. Any parameter exceeding 2^CNT_W is illegal; flag it with an elaboration-time check.
- Reset mid-sequence returns to IDLE immediately; no partial pulses are continued.

Test Plan:
- Normal bring-up: reset 4 cycles, then en=1, PLL model raises pll_lock 10 cycles after pll_reset falls.
  -> pll_reset high exactly 16 cycles.
  -> ready rises 10+2+1+256 cycles after pll_reset falls.
  -> ser_reset falls on the same edge; retry_cnt=0.
- No lock, pll_lock tied 0, en=1:
  -> 8 reset pulses of 16 cycles, spaced 70200 cycles apart.
  -> retry_cnt steps 0..7, then state=5 and fault=1.
  -> en=0 -> IDLE, fault=0, retry_cnt=0.
- Lock glitch in STABLE: pll_lock drops for 3 cycles at 100 cycles into STABLE.
  -> state returns to 2, then 3; ready stays 0.
  -> ready rises only after 256 uninterrupted lock cycles; retry_cnt unchanged.
- Lock loss in RUN: drop pll_lock.
  -> 2 cycles later lock_s=0; the next edge gives lock_lost=1 for exactly one cycle, ready=0, ser_reset=1, state=1.
  -> full re-lock follows and ready returns.
- Enable and reset mid-operation:
  -> en=0 during WAIT_LOCK gives state=0 and pll_reset=1 next edge.
  -> reset=1 during RUN gives all reset values next edge.
  -> en=1 again produces a full 16-cycle reset pulse.
- Simultaneous events: lock_s rises on the same cycle as counter==LOCK_TIMEOUT-1.
  -> goes to STABLE, not PLL_RST; retry_cnt not incremented.

Source files
------------

// File: rtl/lvds_tx_pll_ctrl.sv
// LVDS 7:1 TX PLL power-up / recovery sequencer.
// Pulses the PLL reset, qualifies a synchronized lock, holds the serializer
// in reset until lock has been stable, retries on timeout and faults after
// the retry budget is spent. Every output is registered and decoded from the
// next state, so outputs move on the same edge as the state register.
module lvds_tx_pll_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 70200,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned MAX_RETRY    = 7,
  parameter int unsigned CNT_W        = 17
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       en,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       ser_reset,
  output logic       ready,
  output logic       fault,
  output logic       lock_lost,
  output logic [2:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLL_RST   = 3'd1,
    WAIT_LOCK = 3'd2,
    STABLE    = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [2:0]       RETRY_MAX    = 3'(MAX_RETRY);

  // Parameter legality, checked at elaboration.
  if ((RST_CYCLES < 1) || (LOCK_TIMEOUT < 1) || (LOCK_STABLE < 1) ||
      (longint'(RST_CYCLES)   > (longint'(1) << CNT_W)) ||
      (longint'(LOCK_TIMEOUT) > (longint'(1) << CNT_W)) ||
      (longint'(LOCK_STABLE)  > (longint'(1) << CNT_W))) begin : g_bad_cnt
    $error("lvds_tx_pll_ctrl: cycle parameter out of range for CNT_W");
  end
  if (MAX_RETRY > 7) begin : g_bad_retry
    $error("lvds_tx_pll_ctrl: MAX_RETRY does not fit the 3-bit retry counter");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         retry_q, retry_d;
  logic               sync1_q, lock_s_q;
  logic               pll_reset_q, ser_reset_q, ready_q, fault_q, lock_lost_q;
  logic               pll_reset_d, ser_reset_d, ready_d, fault_d, lock_lost_d;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clkin) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  // State, shared counter, retry count and registered outputs.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      ser_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      ser_reset_q <= ser_reset_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = PLL_RST;
          cnt_d   = '0;
        end
        PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          // Lock takes precedence over a coincident timeout.
          if (lock_s_q) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = FAULT;
            end else begin
              state_d = PLL_RST;
              retry_d = retry_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s_q) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s_q) begin
            state_d     = PLL_RST;
            cnt_d       = '0;
            lock_lost_d = 1'b1;
          end
        end
        FAULT: begin
          cnt_d = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end

    pll_reset_d = (state_d == IDLE) || (state_d == PLL_RST) || (state_d == FAULT);
    ser_reset_d = (state_d != RUN);
    ready_d     = (state_d == RUN);
    fault_d     = (state_d == FAULT);
  end

  assign pll_reset = pll_reset_q;
  assign ser_reset = ser_reset_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign lock_lost = lock_lost_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule
